// File: rtl/ram_bist16x8.sv
// March-style BIST sequencer for a 16x8 single-port RAM (sync write, comb read).
// Writes pat(a) = 2*a to every word, reads back and compares. With the macro
// RAM_BIST_INV_PASS_EN defined, a second write/read pass uses ~pat(a).
// Reports pass/fail, the first failing address and a saturating error count.
module ram_bist16x8 #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [7:0]        err_count
);

  typedef enum logic [2:0] {
    StIdle,
    StW0,
    StR0,
`ifdef RAM_BIST_INV_PASS_EN
    StW1,
    StR1,
`endif
    StDone
  } state_e;

  state_e            state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] pat;
  logic [DATA_W-1:0] expect_val;
  logic              wr_phase;
  logic              rd_phase;
  logic              inv;
  logic              mismatch;
  logic              last;
  logic [7:0]        err_next;

  assign mem_addr = cnt;

  // Phase decode, expected data, compare and RAM strobes (mem_we drops with async reset)
  always_comb begin
    pat      = DATA_W'({cnt, 1'b0});
    wr_phase = (state == StW0);
    rd_phase = (state == StR0);
    inv      = 1'b0;
`ifdef RAM_BIST_INV_PASS_EN
    wr_phase = wr_phase | (state == StW1);
    rd_phase = rd_phase | (state == StR1);
    inv      = (state == StW1) || (state == StR1);
`endif
    expect_val = inv ? ~pat : pat;
    mismatch   = rd_phase && (mem_dout != expect_val);
    err_next   = (mismatch && (err_count != 8'hFF)) ? err_count + 8'd1 : err_count;
    last       = &cnt;
    mem_we     = wr_phase;
    mem_din    = wr_phase ? expect_val : '0;
  end

  // Sequencer state, address counter and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_addr <= '0;
      err_count <= '0;
    end else begin
      if (mismatch) begin
        err_count <= err_next;
        if (err_count == 8'd0) fail_addr <= cnt;
      end
      unique case (state)
        StIdle: begin
          if (start) begin
            state     <= StW0;
            cnt       <= '0;
            busy      <= 1'b1;
            pass      <= 1'b0;
            err_count <= '0;
            fail_addr <= '0;
          end
        end
        StW0: begin
          cnt <= cnt + 1'b1;
          if (last) state <= StR0;
        end
        StR0: begin
          cnt <= cnt + 1'b1;
          if (last) begin
`ifdef RAM_BIST_INV_PASS_EN
            state <= StW1;
`else
            state <= StDone;
            done  <= 1'b1;
            pass  <= (err_next == 8'd0);
`endif
          end
        end
`ifdef RAM_BIST_INV_PASS_EN
        StW1: begin
          cnt <= cnt + 1'b1;
          if (last) state <= StR1;
        end
        StR1: begin
          cnt <= cnt + 1'b1;
          if (last) begin
            state <= StDone;
            done  <= 1'b1;
            // Include a mismatch seen on this final read cycle
            pass  <= (err_next == 8'd0);
          end
        end
`endif
        StDone: begin
          state <= StIdle;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
